// File: rtl/demux_pkg.sv
// demux_pkg: shared defaults, channel state encoding and drop counter width
package demux_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int NUM_CH_DEF = 8;
  localparam int DROP_W = 8;
  typedef enum logic {EMPTY, FULL} ch_state_t;
endpackage

// File: rtl/demux_ch_reg.sv
// demux_ch_reg: one-word channel holding register with same-cycle drain and refill
module demux_ch_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              ready,
  input  logic [DATA_W-1:0] din,
  output logic              can_accept,
  output logic              valid,
  output logic [DATA_W-1:0] data
);
  ch_state_t state, state_nxt;
  assign valid = state == FULL;
  assign can_accept = state == EMPTY || ready;
  // load wins over drain so a refill in the draining cycle leaves no bubble
  always_comb state_nxt = load ? FULL : (ready ? EMPTY : state);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      data  <= '0;
    end else begin
      state <= state_nxt;
      if (load) data <= din;
    end
  end
endmodule

// File: rtl/demux_stream_1_to_n.sv
// demux_stream_1_to_n: routes a valid/ready stream to one channel or broadcasts to all;
// out-of-range selects are accepted, discarded and counted.
module demux_stream_1_to_n
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [DROP_W-1:0]        drop_cnt
);
  logic [NUM_CH-1:0] hit, can_accept, load;
  logic in_range, xfer;
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_CH; k++) hit[k] = in_sel == SEL_W'(k);
  end
  assign in_range = {1'b0, in_sel} < (SEL_W + 1)'(NUM_CH);
  assign in_ready = !rst && (in_bcast ? &can_accept : (in_range ? |(hit & can_accept) : 1'b1));
  assign xfer = in_valid && in_ready;
  assign load = xfer ? (in_bcast ? '1 : (in_range ? hit : '0)) : '0;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    demux_ch_reg #(.DATA_W(DATA_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .load      (load[g]),
      .ready     (out_ready[g]),
      .din       (in_data),
      .can_accept(can_accept[g]),
      .valid     (out_valid[g]),
      .data      (out_data[g*DATA_W +: DATA_W])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else if (xfer && !in_bcast && !in_range && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
  end
endmodule

// File: tb/tb_demux_stream_1_to_n.sv
// tb_demux_stream_1_to_n: directed checks of unicast, backpressure, broadcast, drop and reset
module tb_demux_stream_1_to_n;
  logic clk = 0, rst;
  logic in_valid, in_bcast, in_ready;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic [7:0] out_valid, out_ready, drop_cnt;
  logic [63:0] out_data;
  logic v5, rdy5, bc5;
  logic [7:0] d5, drop5;
  logic [2:0] sel5;
  logic [4:0] ov5, or5;
  logic [39:0] od5;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  demux_stream_1_to_n dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .drop_cnt(drop_cnt)
  );
  demux_stream_1_to_n #(.NUM_CH(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(rdy5), .in_data(d5),
    .in_sel(sel5), .in_bcast(bc5), .out_valid(ov5), .out_ready(or5),
    .out_data(od5), .drop_cnt(drop5)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic all_rdy, any_ov;
    rst = 1; in_valid = 0; in_bcast = 0; in_data = 0; in_sel = 0; out_ready = '1;
    v5 = 0; bc5 = 0; d5 = 8'h33; sel5 = 3'd6; or5 = '1;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_drop5", drop5, 0);
    rst = 0;
    for (int s = 0; s < 8; s++) begin
      in_valid = 1; in_sel = 3'(s); in_data = 8'hA0 + 8'(s);
      #1 check("uni_in_ready", in_ready, 1);
      tick();
      in_valid = 0;
      check("uni_out_valid", out_valid, 64'(8'b1 << s));
      check("uni_data", out_data[s*8 +: 8], 64'(8'hA0 + s));
    end
    tick();
    check("uni_drained", out_valid, 0);
    out_ready = 8'hF7; in_valid = 1; in_sel = 3; in_data = 8'h11;
    #1 check("bp_first_ready", in_ready, 1);
    tick();
    in_data = 8'h22;
    check("bp_second_blocked", in_ready, 0);
    check("bp_held_valid", out_valid, 8'h08);
    check("bp_held_data", out_data[31:24], 8'h11);
    tick();
    check("bp_stable_valid", out_valid, 8'h08);
    check("bp_stable_data", out_data[31:24], 8'h11);
    out_ready = 8'hFF;
    #1 check("bp_passthru_ready", in_ready, 1);
    tick();
    in_valid = 0;
    check("bp_second_valid", out_valid, 8'h08);
    check("bp_second_data", out_data[31:24], 8'h22);
    tick();
    check("bp_drained", out_valid, 0);
    out_ready = 8'hBF; in_valid = 1; in_sel = 6; in_data = 8'h66;
    tick();
    in_bcast = 1; in_sel = 1; in_data = 8'h5C;
    check("bc_blocked", in_ready, 0);
    tick();
    check("bc_ch6_held", out_valid, 8'h40);
    check("bc_ch6_data", out_data[55:48], 8'h66);
    check("bc_others_untouched", out_data[15:8], 8'hA1);
    out_ready = 8'hFF;
    #1 check("bc_ready", in_ready, 1);
    tick();
    in_valid = 0; in_bcast = 0;
    check("bc_all_valid", out_valid, 8'hFF);
    check("bc_all_data", out_data, {8{8'h5C}});
    tick();
    check("bc_drained", out_valid, 0);
    v5 = 1; all_rdy = 1; any_ov = 0;
    for (int i = 0; i < 300; i++) begin
      all_rdy &= rdy5;
      tick();
      any_ov |= |ov5;
      if (i == 9) check("drop_10", drop5, 10);
    end
    v5 = 0;
    check("drop_ready_all", all_rdy, 1);
    check("drop_no_valid", any_ov, 0);
    check("drop_saturate", drop5, 255);
    out_ready = 0; in_valid = 1; in_sel = 0; in_data = 8'h10;
    tick();
    in_sel = 2; in_data = 8'h12;
    tick();
    in_valid = 0;
    check("mid_full", out_valid, 8'h05);
    rst = 1;
    #1 check("mid_rst_in_ready", in_ready, 0);
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_drop5", drop5, 0);
    rst = 0; out_ready = 8'hFF; in_valid = 1; in_sel = 2; in_data = 8'h77;
    #1 check("post_rst_ready", in_ready, 1);
    tick();
    in_valid = 0;
    check("post_rst_valid", out_valid, 8'h04);
    check("post_rst_data", out_data[23:16], 8'h77);
    tick();
    check("post_rst_drained", out_valid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/demux_stream_1_to_n.md
DEMUX_STREAM_1_TO_N -- requirements
Module: demux_stream_1_to_n

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits.
REQ-002 Parameter NUM_CH, default 8: output channel count, range 2..16, power of two not required.
REQ-003 Parameter SEL_W, default clog2(NUM_CH): select width.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 in_data  input  DATA_W  input payload.
REQ-009 in_sel  input  SEL_W  target channel index.
REQ-010 in_bcast  input  1  mode select: 1 = deliver to all channels, in_sel ignored.
REQ-011 out_valid  output  NUM_CH  per-channel word present.
REQ-012 out_ready  input  NUM_CH  per-channel consumer ready.
REQ-013 out_data  output  NUM_CH*DATA_W  channel k payload in bits [k*DATA_W +: DATA_W].
REQ-014 drop_cnt  output  8  count of words dropped for out-of-range select.

Function
REQ-015 Input transfer occurs on a cycle with in_valid=1 and in_ready=1; output transfer on channel k occurs when out_valid[k]=1 and out_ready[k]=1.
REQ-016 Each channel has one holding register with states EMPTY and FULL; out_valid[k] equals (state==FULL).
REQ-017 Channel k "can accept" when EMPTY, or FULL with out_ready[k]=1 in the same cycle (pass-through refill, no bubble).
REQ-018 Unicast (in_bcast=0, in_sel<NUM_CH): in_ready = can-accept of channel in_sel; on transfer, data is loaded and the channel is FULL on the next cycle.
REQ-019 Broadcast (in_bcast=1): in_ready = AND of can-accept over all channels; on transfer, all channels load in_data and become FULL.
REQ-020 Out-of-range select (in_bcast=0, in_sel>=NUM_CH): in_ready=1, word is discarded, drop_cnt increments by 1 and saturates at 255.
REQ-021 Latency input transfer to out_valid: exactly 1 cycle; output data is registered, never combinational from in_data.
REQ-022 in_ready depends combinationally on in_sel, in_bcast and out_ready, never on in_valid.
REQ-023 Channel drained without refill (out_ready[k]=1, no load): FULL to EMPTY next cycle.
REQ-024 FULL with out_ready[k]=0: out_data slice and out_valid[k] hold stable.
REQ-025 Channels not addressed by a transfer are unaffected, including their out_data.
REQ-026 in_bcast takes priority over in_sel.

Reset
REQ-027 While rst=1 at a clock edge: all channels EMPTY, out_valid=0, out_data=0, drop_cnt=0.
REQ-028 Reset mid-operation discards held words without output transfer; first transfer is accepted on the cycle after rst deasserts.
REQ-029 in_ready is 0 while rst=1.

Structure
REQ-030 Package demux_pkg holds the default DATA_W/NUM_CH, the channel state enum (EMPTY, FULL), and the drop-counter width constant.
REQ-031 Sub-module demux_ch_reg implements one channel holding register (load, drain, can-accept); NUM_CH instances are generated.
REQ-032 Top level contains select decode, broadcast AND-reduce, in_ready mux and the drop counter only.

Verification
REQ-033 Unicast sweep: for sel 0..7, send data 0xA0+sel, all out_ready=1 -> out_valid[sel] high for 1 cycle, 1 cycle after transfer, slice = 0xA0+sel, others low.
REQ-034 Backpressure: out_ready[3]=0, send 0x11 then 0x22 to ch3 -> first held FULL, in_ready=0 for second; release out_ready[3] -> 0x11 delivered, 0x22 accepted that same cycle, delivered next.
REQ-035 Broadcast: in_bcast=1, data 0x5C, out_ready[6]=0 with ch6 FULL -> in_ready=0; raise out_ready[6] -> all 8 channels show 0x5C next cycle.
REQ-036 Drop: NUM_CH=5, send 300 words with in_sel=6 -> in_ready=1 throughout, no out_valid, drop_cnt=255.
REQ-037 Reset mid-operation: ch0 and ch2 FULL, assert rst 1 cycle -> out_valid=0, out_data=0, drop_cnt=0; next word to ch2 delivered normally.
